// File: rtl/cnn_memory_module.sv
// cnn_memory_module: input buffer between the controller and the computation stage.
// While enable_memory is high the storage is swept to zero one word per cycle.
// While it is low, words are accepted over a valid/ready handshake until DEPTH
// words are held. The buffer then reports full and serves registered reads.
module cnn_memory_module #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_memory,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   load_count,
    output logic              load_done
);

    localparam int CNT_W = ADDR_W + 1;

    // Index of the last stored word; both the sweep and the load stop here.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    // load_count needs one extra bit so that it can hold DEPTH itself.
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    typedef enum logic [1:0] {
        ST_CLEAR    = 2'd0,
        ST_IDLE_CLR = 2'd1,
        ST_LOAD     = 2'd2,
        ST_FULL     = 2'd3
    } state_t;

    logic [DATA_W-1:0] mem_r [DEPTH];

    state_t            state_r;
    state_t            state_next_s;
    logic [ADDR_W-1:0] clr_ptr_r;
    logic [ADDR_W-1:0] clr_ptr_next_s;
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] wr_ptr_next_s;
    logic [CNT_W-1:0]  load_count_r;
    logic [CNT_W-1:0]  load_count_next_s;
    logic              in_ready_r;
    logic              load_done_r;
    logic [DATA_W-1:0] rd_data_r;

    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_waddr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic              rd_in_range_s;

    // Addresses at or beyond DEPTH read back as zero instead of touching the array.
    assign rd_in_range_s = ({1'b0, rd_addr} < DEPTH_CNT);

    // Next-state, pointer/counter updates and the single storage write port.
    always_comb begin
        state_next_s      = state_r;
        clr_ptr_next_s    = clr_ptr_r;
        wr_ptr_next_s     = wr_ptr_r;
        load_count_next_s = load_count_r;
        mem_we_s          = 1'b0;
        mem_waddr_s       = clr_ptr_r;
        mem_wdata_s       = DATA_ZERO;

        case (state_r)
            ST_CLEAR: begin
                // A clear request here does not restart the sweep; it only
                // decides where the sweep lands once the last word is zeroed.
                mem_we_s       = 1'b1;
                mem_waddr_s    = clr_ptr_r;
                mem_wdata_s    = DATA_ZERO;
                clr_ptr_next_s = clr_ptr_r + ADDR_ONE;
                if (clr_ptr_r == LAST_ADDR) begin
                    if (enable_memory) begin
                        state_next_s = ST_IDLE_CLR;
                    end else begin
                        state_next_s = ST_LOAD;
                    end
                end else begin
                    state_next_s = ST_CLEAR;
                end
            end

            ST_IDLE_CLR: begin
                if (!enable_memory) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_IDLE_CLR;
                end
            end

            ST_LOAD: begin
                if (enable_memory) begin
                    // Clear wins over a word offered in the same cycle.
                    state_next_s      = ST_CLEAR;
                    clr_ptr_next_s    = ADDR_ZERO;
                    wr_ptr_next_s     = ADDR_ZERO;
                    load_count_next_s = CNT_ZERO;
                end else if (in_valid) begin
                    mem_we_s    = 1'b1;
                    mem_waddr_s = wr_ptr_r;
                    mem_wdata_s = in_data;
                    if (wr_ptr_r == LAST_ADDR) begin
                        // Pointer parks on the last word; FULL never writes.
                        state_next_s = ST_FULL;
                    end else begin
                        wr_ptr_next_s = wr_ptr_r + ADDR_ONE;
                    end
                    if (load_count_r < DEPTH_CNT) begin
                        load_count_next_s = load_count_r + CNT_ONE;
                    end else begin
                        load_count_next_s = load_count_r;
                    end
                end else begin
                    state_next_s = ST_LOAD;
                end
            end

            ST_FULL: begin
                if (enable_memory) begin
                    state_next_s      = ST_CLEAR;
                    clr_ptr_next_s    = ADDR_ZERO;
                    wr_ptr_next_s     = ADDR_ZERO;
                    load_count_next_s = CNT_ZERO;
                end else begin
                    state_next_s = ST_FULL;
                end
            end

            default: begin
                state_next_s      = ST_CLEAR;
                clr_ptr_next_s    = ADDR_ZERO;
                wr_ptr_next_s     = ADDR_ZERO;
                load_count_next_s = CNT_ZERO;
            end
        endcase
    end

    // State, pointers, counter and the Moore flags decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_CLEAR;
            clr_ptr_r    <= ADDR_ZERO;
            wr_ptr_r     <= ADDR_ZERO;
            load_count_r <= CNT_ZERO;
            in_ready_r   <= 1'b0;
            load_done_r  <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            clr_ptr_r    <= clr_ptr_next_s;
            wr_ptr_r     <= wr_ptr_next_s;
            load_count_r <= load_count_next_s;
            in_ready_r   <= (state_next_s == ST_LOAD);
            load_done_r  <= (state_next_s == ST_FULL);
        end
    end

    // Storage array; reset leaves contents alone so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (mem_we_s && !rst) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Registered read port; a same-cycle write to the address returns the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r <= DATA_ZERO;
        end else if (rd_en) begin
            if (rd_in_range_s) begin
                rd_data_r <= mem_r[rd_addr];
            end else begin
                rd_data_r <= DATA_ZERO;
            end
        end
    end

    assign in_ready   = in_ready_r;
    assign load_done  = load_done_r;
    assign load_count = load_count_r;
    assign rd_data    = rd_data_r;

endmodule

// File: tb/tb_cnn_memory_module.sv
// Directed bench for cnn_memory_module: a DEPTH=64 instance carries the main
// sequence, a DEPTH=40 instance covers saturation and out-of-range reads.
module tb_cnn_memory_module;

    localparam int DW = 8;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable_memory;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          rd_en_b;
    logic [AW-1:0] rd_addr_b;

    logic          in_ready;
    logic [DW-1:0] rd_data;
    logic [AW:0]   load_count;
    logic          load_done;

    logic          in_ready_b;
    logic [DW-1:0] rd_data_b;
    logic [AW:0]   load_count_b;
    logic          load_done_b;

    int checks = 0;
    int errors = 0;

    cnn_memory_module #(.DATA_W(DW), .DEPTH(64), .ADDR_W(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable_memory (enable_memory),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .load_count    (load_count),
        .load_done     (load_done)
    );

    cnn_memory_module #(.DATA_W(DW), .DEPTH(40), .ADDR_W(AW)) dut_b (
        .clk           (clk),
        .rst           (rst),
        .enable_memory (enable_memory),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready_b),
        .rd_en         (rd_en_b),
        .rd_addr       (rd_addr_b),
        .rd_data       (rd_data_b),
        .load_count    (load_count_b),
        .load_done     (load_done_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [AW-1:0] a);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en   = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        enable_memory = 1'b1;
        in_valid      = 1'b0;
        in_data       = 8'h00;
        rd_en         = 1'b0;
        rd_addr       = 6'd0;
        rd_en_b       = 1'b0;
        rd_addr_b     = 6'd0;

        // Reset values
        tick();
        chk("rst_in_ready",   32'(in_ready),   32'd0);
        chk("rst_load_done",  32'(load_done),  32'd0);
        chk("rst_load_count", 32'(load_count), 32'd0);
        chk("rst_rd_data",    32'(rd_data),    32'd0);
        chk("rst_b_in_ready", 32'(in_ready_b), 32'd0);
        rst = 1'b0;

        // Reset sweep: in_ready low for the whole 64-cycle sweep, then IDLE_CLR
        for (int k = 1; k <= 64; k++) begin
            tick();
            chk("sweep_in_ready", 32'(in_ready), 32'd0);
        end
        rd(6'd0);
        chk("sweep_rd0", 32'(rd_data), 32'd0);
        rd(6'd37);
        chk("sweep_rd37", 32'(rd_data), 32'd0);
        rd(6'd63);
        chk("sweep_rd63", 32'(rd_data), 32'd0);
        chk("idle_in_ready", 32'(in_ready), 32'd0);

        // Full load of 0x00..0x3F
        enable_memory = 1'b0;
        tick();
        chk("load_in_ready", 32'(in_ready), 32'd1);
        chk("load_done0",    32'(load_done), 32'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            in_data = 8'(i);
            tick();
            if (i == 62) begin
                chk("load_count63", 32'(load_count), 32'd63);
                chk("in_ready63",   32'(in_ready),   32'd1);
            end
        end
        chk("full_load_count", 32'(load_count), 32'd64);
        chk("full_load_done",  32'(load_done),  32'd1);
        chk("full_in_ready",   32'(in_ready),   32'd0);
        chk("b_load_count",    32'(load_count_b), 32'd40);
        chk("b_load_done",     32'(load_done_b),  32'd1);

        // Word presented while FULL is dropped
        in_data = 8'hAA;
        tick();
        tick();
        in_valid = 1'b0;
        chk("full_hold_count", 32'(load_count), 32'd64);
        rd(6'd5);
        chk("full_rd5", 32'(rd_data), 32'h05);
        rd(6'd63);
        chk("full_rd63", 32'(rd_data), 32'h3F);
        rd_en_b   = 1'b1;
        rd_addr_b = 6'd45;
        tick();
        chk("b_rd45_oob", 32'(rd_data_b), 32'd0);
        rd_addr_b = 6'd39;
        tick();
        chk("b_rd39", 32'(rd_data_b), 32'h27);
        rd_en_b = 1'b0;

        // Clear from FULL with early release 5 cycles into the sweep
        enable_memory = 1'b1;
        tick();
        chk("clr_load_count", 32'(load_count), 32'd0);
        chk("clr_load_done",  32'(load_done),  32'd0);
        chk("clr_in_ready",   32'(in_ready),   32'd0);
        for (int k = 1; k <= 5; k++) begin
            tick();
        end
        enable_memory = 1'b0;
        for (int k = 6; k <= 63; k++) begin
            tick();
            chk("early_in_ready", 32'(in_ready), 32'd0);
        end
        tick();
        chk("early_release_ready", 32'(in_ready), 32'd1);

        // Backpressure: in_valid on even steps only
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = 8'h10 + 8'(i);
            tick();
            if (i == 1) begin
                chk("gap_count1", 32'(load_count), 32'd1);
            end
        end
        in_valid = 1'b0;
        chk("gap_count5", 32'(load_count), 32'd5);
        rd(6'd1);
        chk("gap_rd1", 32'(rd_data), 32'h12);
        rd(6'd5);
        chk("gap_rd5", 32'(rd_data), 32'h00);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'h20 + 8'(i);
            tick();
        end
        chk("gap_count10", 32'(load_count), 32'd10);

        // Mid-load clear with a word offered in the same cycle
        enable_memory = 1'b1;
        in_data       = 8'h99;
        tick();
        in_valid = 1'b0;
        chk("mid_load_count", 32'(load_count), 32'd0);
        chk("mid_load_done",  32'(load_done),  32'd0);
        chk("mid_in_ready",   32'(in_ready),   32'd0);
        rd(6'd10);
        chk("mid_rd10_no99", 32'(rd_data), 32'h00);
        rd(6'd3);
        chk("mid_rd3_old", 32'(rd_data), 32'h16);
        for (int k = 0; k < 70; k++) begin
            tick();
        end
        chk("mid_idle_ready", 32'(in_ready), 32'd0);
        rd(6'd3);
        chk("mid_rd3_swept", 32'(rd_data), 32'h00);

        // Read-before-write on address 63
        enable_memory = 1'b0;
        tick();
        in_valid = 1'b1;
        for (int i = 0; i < 63; i++) begin
            in_data = 8'(i);
            tick();
        end
        in_data = 8'h55;
        rd_en   = 1'b1;
        rd_addr = 6'd63;
        tick();
        in_valid = 1'b0;
        rd_en    = 1'b0;
        chk("rbw_old",       32'(rd_data),    32'h00);
        chk("rbw_load_done", 32'(load_done),  32'd1);
        chk("rbw_count",     32'(load_count), 32'd64);
        rd(6'd63);
        chk("rbw_new", 32'(rd_data), 32'h55);
        tick();
        chk("rd_hold", 32'(rd_data), 32'h55);

        // Reset while FULL
        rst     = 1'b1;
        rd_en   = 1'b1;
        rd_addr = 6'd63;
        tick();
        chk("rst2_in_ready",   32'(in_ready),   32'd0);
        chk("rst2_load_done",  32'(load_done),  32'd0);
        chk("rst2_load_count", 32'(load_count), 32'd0);
        chk("rst2_rd_data",    32'(rd_data),    32'd0);
        rst   = 1'b0;
        rd_en = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cnn_memory_module.md
Name: cnn_memory_module

Overview:
- Input-buffer stage driven by the controller's `enable_memory` output. It sits directly downstream of the controller and upstream of the computation module.
- While `enable_memory`=1 it sweeps its storage to zero.
- While `enable_memory`=0 it accepts a pixel/weight stream over a valid/ready handshake into DEPTH words. It then flags completion and serves synchronous reads to the computation stage.

Parameters:
- DATA_W, 8, width of each stored word
- DEPTH, 64, number of stored words (1 < DEPTH <= 2**ADDR_W)
- ADDR_W, 6, width of address/pointer fields

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- enable_memory  input  1  from controller; 1 = clear stored data, 0 = load input data
- in_valid  input  1  upstream word available
- in_data  input  DATA_W  upstream word
- in_ready  output  1  block can accept a word this cycle
- rd_en  input  1  read request from computation module
- rd_addr  input  ADDR_W  read address
- rd_data  output  DATA_W  registered read data
- load_count  output  ADDR_W+1  number of words accepted since last clear
- load_done  output  1  DEPTH words stored, buffer full

Behaviour:

Reset and interface:
- Reset (rst=1 at a clk edge) has priority over everything. It sets:
  - state=CLEAR, clr_ptr=0, wr_ptr=0
  - load_count=0, load_done=0, rd_data=0
  - storage contents untouched by reset itself; the CLEAR sweep zeroes them.
- Reset is synchronous and active-high, on a single clock `clk`.

States:
- CLEAR: write 0 to address clr_ptr each cycle and increment clr_ptr. After writing DEPTH-1, go to IDLE_CLR if enable_memory=1, else LOAD. Sweep takes exactly DEPTH cycles. in_ready=0.
- IDLE_CLR: storage all zero; wait. When enable_memory=0, go to LOAD. in_ready=0.
- LOAD: in_ready=1.
  - Transfer occurs when in_valid=1 and in_ready=1.
  - On transfer: mem[wr_ptr]<=in_data, wr_ptr+1, load_count+1.
  - On the transfer at wr_ptr=DEPTH-1, go to FULL next cycle.
  - in_valid=0 holds state; no write occurs.
- FULL: in_ready=0, load_done=1. in_data ignored. Stays until enable_memory=1.

Clear requests:
- enable_memory=1 seen in LOAD or FULL: next state CLEAR. At the same edge clr_ptr=0, wr_ptr=0, load_count=0, load_done=0.
  - Any word presented that same cycle is NOT written; in_ready is already 0 the cycle after.
- enable_memory=1 during CLEAR: no restart; the sweep continues.
- enable_memory falling during CLEAR: the sweep completes first, then LOAD.

Outputs and timing:
- in_ready and load_done are Moore outputs decoded from registered state. No combinational path from in_valid or enable_memory.

Read port:
- rd_en=1 at edge N gives rd_data = mem[rd_addr] after edge N.
- rd_en=0 holds rd_data.
- rd_addr >= DEPTH returns 0.
- Read and write to the same address in the same cycle return the old contents (read-before-write).
- Reads are legal in every state.

Counters:
- load_count saturates at DEPTH and never wraps.
- wr_ptr is never used beyond DEPTH-1.

Test Plan:
- Reset sweep: assert rst 1 cycle with enable_memory=1 -> in_ready=0 for 64 cycles, then state IDLE_CLR; reading addr 0/37/63 gives rd_data=0 one cycle after rd_en.
- Full load: drop enable_memory, drive in_valid=1 with in_data=0x00..0x3F -> 64 transfers, load_count=64, load_done=1 and in_ready=0 one cycle after the 64th; reading addr 5 returns 0x05.
- Backpressure/gaps: toggle in_valid every other cycle -> only valid cycles write; load_count increments only on transfers; a word presented in FULL (0xAA) is not stored, and addr 63 keeps 0x3F.
- Mid-load clear: after 10 transfers raise enable_memory with in_valid=1, in_data=0x99 -> no write of 0x99; load_count=0, load_done=0, sweep restarts at addr 0; after 64 cycles addr 3 reads 0.
- Early release: drop enable_memory 5 cycles into a sweep -> in_ready stays 0 until the sweep ends (64 cycles after it began), then rises.
- Read corner cases: rd_addr=0x3F with concurrent write of 0x55 to addr 63 -> rd_data old value, next read 0x55. With DEPTH=40, rd_addr=45 -> rd_data=0. rst mid-FULL -> all outputs at reset values next cycle.
